load_store_unit: RTL and testbench

Multi-cycle load/store initiator that sits between the RISC-V core's execute stage and the word-addressed data memory. It accepts one byte, halfword or word access per request and drives the memory's write-enable, read-enable, address and write-data inputs. Loads are extracted and sign- or zero-extended from the returned word; sub-word stores are performed as read-modify-write. Misaligned or illegal accesses complete with an error flag and never touch memory.

---
 rtl/lsu_defs_pkg.sv | 46 ++++
 rtl/lsu_lane_align.sv | 58 +++++
 rtl/load_store_unit.sv | 129 ++++++++++++
 tb/tb_load_store_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_defs_pkg.sv
// rtl/lsu_defs_pkg.sv - shared encodings for the load/store unit
//
// Purpose: RISC-V funct3 size codes, FSM state encodings and the request
// legality check shared by the load/store unit and its lane aligner.
// Ports: none (package).

package lsu_defs;

  // RISC-V funct3 size codes
  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  // FSM state encodings
  localparam logic [1:0] LSU_ST_IDLE  = 2'd0;
  localparam logic [1:0] LSU_ST_READ  = 2'd1;
  localparam logic [1:0] LSU_ST_WRITE = 2'd2;
  localparam logic [1:0] LSU_ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = LSU_ST_IDLE,
    ST_READ  = LSU_ST_READ,
    ST_WRITE = LSU_ST_WRITE,
    ST_DONE  = LSU_ST_DONE
  } lsu_state_t;

  // A request is illegal if the size code is reserved, a store asks for an
  // unsigned size, or the address is not naturally aligned for the size.
  function automatic logic lsu_illegal(input logic       write,
                                       input logic [2:0] funct3,
                                       input logic [1:0] lane);
    logic bad;
    case (funct3)
      LSU_B:   bad = 1'b0;
      LSU_BU:  bad = write;
      LSU_H:   bad = lane[0];
      LSU_HU:  bad = write | lane[0];
      LSU_W:   bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - combinational load extraction and store merge
//
// Purpose: selects the byte/halfword lane of a memory word for loads
// (with sign or zero extension) and splices store data into a word for
// read-modify-write stores.
// Ports:
//   funct3       in   size code of the access
//   lane         in   byte address bits [1:0]
//   read_word    in   word returned by memory (load source)
//   base_word    in   previously read word (merge source)
//   store_data   in   right-justified store data
//   load_data    out  extended load result
//   merged_word  out  word to write back to memory

module lsu_lane_align
  import lsu_defs::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3,
  input  logic [1:0]            lane,
  input  logic [DATA_WIDTH-1:0] read_word,
  input  logic [DATA_WIDTH-1:0] base_word,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] merged_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = read_word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? read_word[31:16] : read_word[15:0];

    case (funct3)
      LSU_B:   load_data = {{24{byte_sel[7]}}, byte_sel};
      LSU_BU:  load_data = {24'b0, byte_sel};
      LSU_H:   load_data = {{16{half_sel[15]}}, half_sel};
      LSU_HU:  load_data = {16'b0, half_sel};
      default: load_data = read_word;
    endcase
  end

  // Untouched lanes keep the value read from memory.
  always_comb begin
    merged_word = base_word;
    case (funct3)
      LSU_B: merged_word[{lane, 3'b000} +: 8] = store_data[7:0];
      LSU_H: begin
        if (lane[1]) merged_word[31:16] = store_data[15:0];
        else         merged_word[15:0]  = store_data[15:0];
      end
      default: merged_word = store_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multi-cycle load/store initiator
//
// Purpose: accepts one byte/halfword/word load or store, drives a
// word-addressed memory, extends loads and performs sub-word stores as
// read-modify-write. Illegal or misaligned requests finish with an error
// and never strobe memory.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   Req_i               request strobe (sampled only when idle)
//   Write_i             1 = store, 0 = load
//   Funct3_i            RISC-V size code
//   Address_i           byte address
//   Store_Data_i        right-justified store data
//   Busy_o              access in progress, through the Done cycle
//   Done_o, Error_o     completion pulse and its error flag
//   Load_Data_o         extended result of the last good load
//   Mem_Read_o          memory read enable
//   Mem_Write_o         memory write enable
//   Mem_Address_o       word-aligned memory address
//   Mem_Write_Data_o    word to write (0 when not writing)
//   Mem_Read_Data_i     combinational memory read word

module load_store_unit
  import lsu_defs::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Req_i,
  input  logic                  Write_i,
  input  logic [2:0]            Funct3_i,
  input  logic [DATA_WIDTH-1:0] Address_i,
  input  logic [DATA_WIDTH-1:0] Store_Data_i,
  output logic                  Busy_o,
  output logic                  Done_o,
  output logic                  Error_o,
  output logic [DATA_WIDTH-1:0] Load_Data_o,
  output logic                  Mem_Read_o,
  output logic                  Mem_Write_o,
  output logic [DATA_WIDTH-1:0] Mem_Address_o,
  output logic [DATA_WIDTH-1:0] Mem_Write_Data_o,
  input  logic [DATA_WIDTH-1:0] Mem_Read_Data_i
);

  lsu_state_t            state;
  logic                  write_q;
  logic [2:0]            funct3_q;
  logic [1:0]            lane_q;
  logic [DATA_WIDTH-1:0] store_q;
  logic [DATA_WIDTH-1:0] merge_q;
  logic                  err_q;

  logic                  req_illegal;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [DATA_WIDTH-1:0] merged;

  assign req_illegal = lsu_illegal(Write_i, Funct3_i, Address_i[1:0]);

  // Loads extract from the live memory word; stores merge into the word
  // captured during READ.
  lsu_lane_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lane_align (
    .funct3      (funct3_q),
    .lane        (lane_q),
    .read_word   (Mem_Read_Data_i),
    .base_word   (merge_q),
    .store_data  (store_q),
    .load_data   (load_ext),
    .merged_word (merged)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      write_q       <= 1'b0;
      funct3_q      <= LSU_B;
      lane_q        <= 2'b00;
      store_q       <= '0;
      merge_q       <= '0;
      err_q         <= 1'b0;
      Load_Data_o   <= '0;
      Mem_Address_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Req_i) begin
            write_q       <= Write_i;
            funct3_q      <= Funct3_i;
            lane_q        <= Address_i[1:0];
            store_q       <= Store_Data_i;
            err_q         <= req_illegal;
            Mem_Address_o <= {Address_i[DATA_WIDTH-1:2], 2'b00};
            if (req_illegal)
              state <= ST_DONE;
            else if (Write_i && (Funct3_i == LSU_W))
              state <= ST_WRITE;  // full-word store needs no read
            else
              state <= ST_READ;   // loads and sub-word stores read first
          end
        end
        ST_READ: begin
          if (write_q) begin
            merge_q <= Mem_Read_Data_i;
            state   <= ST_WRITE;
          end else begin
            Load_Data_o <= load_ext;
            state       <= ST_DONE;
          end
        end
        ST_WRITE: state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Strobes and status decode directly from the registered state, so a
  // write in progress at a reset edge is still seen by memory on that edge.
  assign Busy_o      = (state != ST_IDLE);
  assign Done_o      = (state == ST_DONE);
  assign Error_o     = (state == ST_DONE) && err_q;
  assign Mem_Read_o  = (state == ST_READ);
  assign Mem_Write_o = (state == ST_WRITE);

  assign Mem_Write_Data_o = Mem_Write_o ? merged : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit

module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, write;
  logic [2:0]  funct3;
  logic [31:0] address, store_data;
  logic        busy, done, error;
  logic [31:0] load_data;
  logic        mem_read, mem_write;
  logic [31:0] mem_address, mem_wdata, mem_rdata;

  logic [31:0] mem [16];
  logic [7:0]  ref_mem [64];
  logic [31:0] ref_load;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] last_ld, last_wd;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .Req_i            (req),
    .Write_i          (write),
    .Funct3_i         (funct3),
    .Address_i        (address),
    .Store_Data_i     (store_data),
    .Busy_o           (busy),
    .Done_o           (done),
    .Error_o          (error),
    .Load_Data_o      (load_data),
    .Mem_Read_o       (mem_read),
    .Mem_Write_o      (mem_write),
    .Mem_Address_o    (mem_address),
    .Mem_Write_Data_o (mem_wdata),
    .Mem_Read_Data_i  (mem_rdata)
  );

  assign mem_rdata = mem[mem_address[5:2]];

  always @(posedge clk) begin
    if (mem_write) mem[mem_address[5:2]] <= mem_wdata;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic int acc_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic ref_illegal(input logic w, input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
    if (w && (f3 == 3'b100 || f3 == 3'b101)) return 1'b1;
    return (int'(a[1:0]) % acc_size(f3)) != 0;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int b = int'(a[5:2]) * 4;
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  function automatic logic [31:0] ref_load_value(input logic [2:0] f3, input logic [31:0] a);
    int n = acc_size(f3);
    longint v = 0;
    for (int i = 0; i < n; i++)
      v += longint'(ref_mem[int'(a[5:0]) + i]) << (8 * i);
    if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1)))
      v += (longint'(1) << 32) - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic run_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input string tag);
    int lat = 0, nrd = 0, nwr = 0;
    logic overlap = 0, addr_ok = 1, wd_zero = 1, busy_ok = 1, err_seen = 0;
    logic bad;
    int exp_lat, exp_rd, exp_wr;
    logic [31:0] exp_addr;

    bad = ref_illegal(w, f3, a);
    exp_addr = {a[31:2], 2'b00};
    exp_lat = bad ? 1 : (!w ? 2 : (f3 == 3'b010 ? 2 : 3));
    exp_rd  = (bad || (w && f3 == 3'b010)) ? 0 : 1;
    exp_wr  = (!bad && w) ? 1 : 0;

    @(negedge clk);
    req = 1'b1; write = w; funct3 = f3; address = a; store_data = d;
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (mem_read && mem_write) overlap = 1'b1;
      if (mem_read) nrd++;
      if (mem_write) begin
        nwr++;
        last_wd = mem_wdata;
      end else if (mem_wdata !== 32'h0) wd_zero = 1'b0;
      if (!bad && mem_address !== exp_addr) addr_ok = 1'b0;
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        lat = c;
        err_seen = error;
        last_ld = load_data;
        break;
      end
      // garbage on the request inputs while busy must be ignored
      req = 1'($urandom); write = 1'($urandom); funct3 = 3'($urandom);
      address = 32'($urandom_range(0, 63)); store_data = $urandom;
    end
    req = 1'b0;

    if (!bad && !w) ref_load = ref_load_value(f3, a);
    if (!bad && w)
      for (int i = 0; i < acc_size(f3); i++)
        ref_mem[int'(a[5:0]) + i] = d[8*i +: 8];

    check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, " error"}, 32'(err_seen), 32'(bad));
    check_eq({tag, " read_cycles"}, 32'(nrd), 32'(exp_rd));
    check_eq({tag, " write_cycles"}, 32'(nwr), 32'(exp_wr));
    check_eq({tag, " rd_wr_overlap"}, 32'(overlap), 32'h0);
    check_eq({tag, " address_stable"}, 32'(addr_ok), 32'h1);
    check_eq({tag, " wdata_zero_idle"}, 32'(wd_zero), 32'h1);
    check_eq({tag, " busy"}, 32'(busy_ok), 32'h1);
    check_eq({tag, " load_data"}, last_ld, ref_load);
    if (exp_wr == 1) check_eq({tag, " write_data"}, last_wd, ref_word(a));
    check_eq({tag, " mem_word"}, mem[a[5:2]], ref_word(a));
  endtask

  initial begin
    logic [2:0] legal_f3 [5];
    logic [31:0] a;
    logic [2:0] f3;
    logic w, saw_wr, saw_done;

    legal_f3[0] = 3'b000; legal_f3[1] = 3'b001; legal_f3[2] = 3'b010;
    legal_f3[3] = 3'b100; legal_f3[4] = 3'b101;
    ref_load = 32'h0;
    last_ld = 32'h0; last_wd = 32'h0;
    req = 0; write = 0; funct3 = 0; address = 0; store_data = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset busy", 32'(busy), 32'h0);
    check_eq("reset done", 32'(done), 32'h0);
    check_eq("reset error", 32'(error), 32'h0);
    check_eq("reset strobes", {30'h0, mem_read, mem_write}, 32'h0);
    check_eq("reset load_data", load_data, 32'h0);
    check_eq("reset address", mem_address, 32'h0);
    check_eq("reset wdata", mem_wdata, 32'h0);
    reset = 1'b0;

    // preload every word through the unit itself
    for (int i = 0; i < 16; i++) run_req(1'b1, 3'b010, 32'(i * 4), $urandom, "preload");
    run_req(1'b1, 3'b010, 32'h10, 32'h8899AABB, "preload_10");
    run_req(1'b1, 3'b010, 32'h14, 32'h00000000, "preload_14");

    run_req(1'b0, 3'b000, 32'h13, 32'h0, "lb_13");
    check_eq("lb_13 value", last_ld, 32'hFFFFFF88);
    run_req(1'b0, 3'b100, 32'h12, 32'h0, "lbu_12");
    check_eq("lbu_12 value", last_ld, 32'h00000099);
    run_req(1'b0, 3'b101, 32'h10, 32'h0, "lhu_10");
    check_eq("lhu_10 value", last_ld, 32'h0000AABB);
    run_req(1'b1, 3'b000, 32'h11, 32'h1234565A, "sb_11");
    check_eq("sb_11 wdata", last_wd, 32'h88995ABB);
    run_req(1'b0, 3'b010, 32'h10, 32'h0, "lw_10");
    check_eq("lw_10 value", last_ld, 32'h88995ABB);
    run_req(1'b1, 3'b010, 32'h14, 32'hDEADBEEF, "sw_14");
    check_eq("sw_14 mem", mem[5], 32'hDEADBEEF);
    run_req(1'b0, 3'b001, 32'h11, 32'h0, "lh_11_err");
    run_req(1'b1, 3'b100, 32'h10, 32'h0, "sbu_err");
    check_eq("err load_data held", last_ld, 32'h88995ABB);

    // reset during the READ cycle of an SH read-modify-write
    run_req(1'b1, 3'b010, 32'h10, 32'h8899AABB, "restore_10");
    @(negedge clk);
    req = 1'b1; write = 1'b1; funct3 = 3'b001; address = 32'h12; store_data = 32'h0000CAFE;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    check_eq("rst_mid read_strobe", 32'(mem_read), 32'h1);
    saw_wr = mem_write;
    reset = 1'b1;
    @(negedge clk);
    saw_wr |= mem_write;
    check_eq("rst_mid busy", 32'(busy), 32'h0);
    check_eq("rst_mid done", 32'(done), 32'h0);
    check_eq("rst_mid error", 32'(error), 32'h0);
    check_eq("rst_mid load_data", load_data, 32'h0);
    check_eq("rst_mid address", mem_address, 32'h0);
    check_eq("rst_mid wdata", mem_wdata, 32'h0);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      saw_wr |= mem_write;
      saw_done |= done;
    end
    check_eq("rst_mid no_write", 32'(saw_wr), 32'h0);
    check_eq("rst_mid no_done", 32'(saw_done), 32'h0);
    check_eq("rst_mid mem_10", mem[4], 32'h8899AABB);
    ref_load = 32'h0;
    last_ld = 32'h0;

    for (int n = 0; n < 300; n++) begin
      w = 1'($urandom);
      f3 = ($urandom_range(0, 4) != 0) ? legal_f3[$urandom_range(0, 4)] : 3'($urandom);
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) a = a & ~32'(acc_size(f3) - 1);
      run_req(w, f3, a, $urandom, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
